// File: rtl/halflife_meter.sv
// Half-life meter: captures a reference sample on start and counts
// enabled ticks until the sample decays to half the reference.
module halflife_meter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       status
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b01;
  localparam logic [1:0] ST_OVF  = 2'b10;
  localparam logic [1:0] ST_RISE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] result_d;
  logic [1:0]       status_d;
  logic             done_d;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] target;

  assign n      = count_q + 1'b1;
  assign target = ref_q >> 1;
  assign busy   = (state == MEAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ref_q   <= '0;
      count_q <= '0;
      done    <= 1'b0;
      result  <= '0;
      status  <= ST_OK;
    end else begin
      state   <= state_d;
      ref_q   <= ref_d;
      count_q <= count_d;
      done    <= done_d;
      result  <= result_d;
      status  <= status_d;
    end
  end

  always_comb begin
    state_d  = state;
    ref_d    = ref_q;
    count_d  = count_q;
    done_d   = 1'b0;
    result_d = result;
    status_d = status;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (sample == '0) begin
            result_d = '0;
            status_d = ST_ZERO;
            done_d   = 1'b1;
          end else begin
            ref_d   = sample;
            count_d = '0;
            state_d = MEAS;
          end
        end
      end
      MEAS: begin
        // Halfway wins over rise, rise over overflow.
        if (sample_en) begin
          if (sample <= target) begin
            result_d = n;
            status_d = ST_OK;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else if (sample > ref_q) begin
            result_d = n;
            status_d = ST_RISE;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else if (n == CNT_MAX) begin
            result_d = CNT_MAX;
            status_d = ST_OVF;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            count_d = n;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_halflife_meter.sv
// Randomized and directed bench for halflife_meter against a
// tick-counting reference model.
module tb_halflife_meter;

  localparam int W = 4;
  localparam int C = 4;
  localparam int CMAX = (1 << C) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] sample;
  logic         sample_en;
  logic         busy;
  logic         done;
  logic [C-1:0] result;
  logic [1:0]   status;

  int n_vec = 0;
  int n_err = 0;

  int m_meas, m_ref, m_ticks, m_res, m_st, m_done;

  halflife_meter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample    (sample),
    .sample_en (sample_en),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_meas = 0; m_ref = 0; m_ticks = 0;
    m_res = 0; m_st = 0; m_done = 0;
  endtask

  // One clock edge of the measurement rules, in plain integers.
  task automatic model_step(input int s, input int smp, input int e);
    m_done = 0;
    if (m_meas == 0) begin
      if (s != 0) begin
        if (smp == 0) begin
          m_res = 0; m_st = 1; m_done = 1;
        end else begin
          m_meas = 1; m_ref = smp; m_ticks = 0;
        end
      end
    end else if (e != 0) begin
      m_ticks = m_ticks + 1;
      if (smp <= m_ref / 2) begin
        m_res = m_ticks; m_st = 0; m_done = 1; m_meas = 0;
      end else if (smp > m_ref) begin
        m_res = m_ticks; m_st = 3; m_done = 1; m_meas = 0;
      end else if (m_ticks == CMAX) begin
        m_res = CMAX; m_st = 2; m_done = 1; m_meas = 0;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".busy"},   busy,   m_meas);
    check({tag, ".done"},   done,   m_done);
    check({tag, ".result"}, result, m_res);
    check({tag, ".status"}, status, m_st);
  endtask

  task automatic cycle(input int s, input int smp, input int e);
    start     = (s != 0);
    sample    = smp[W-1:0];
    sample_en = (e != 0);
    @(posedge clk);
    model_step(s, smp, e);
    #1;
    check_outs("cyc");
  endtask

  initial begin
    int seq [5];
    seq = '{11, 10, 9, 8, 6};
    rst = 1'b1; start = 1'b0; sample = '0; sample_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    rst = 1'b0;

    // Decay at full tick rate
    cycle(1, 12, 1);
    check("decay.busy_on", busy, 1);
    foreach (seq[i]) cycle(0, seq[i], 1);
    check("decay.done", done, 1);
    check("decay.result", result, 5);
    check("decay.busy_off", busy, 0);
    cycle(0, 6, 0);

    // Gated ticks: enable every third cycle
    cycle(1, 12, 0);
    foreach (seq[i]) begin
      cycle(0, seq[i], 0);
      cycle(0, seq[i], 0);
      cycle(0, seq[i], 1);
    end
    check("gated.result", result, 5);
    check("gated.done", done, 1);

    // Zero reference, back to back
    cycle(1, 0, 0);
    check("zero.status", status, 1);
    check("zero.busy", busy, 0);
    cycle(1, 0, 0);
    check("zero2.done", done, 1);
    cycle(0, 0, 0);

    // ref = 1
    cycle(1, 1, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    check("ref1.result", result, 3);
    check("ref1.status", status, 0);

    // Rise abort and halfway precedence
    cycle(1, 8, 0);
    cycle(0, 9, 1);
    check("rise.status", status, 3);
    cycle(1, 8, 0);
    cycle(0, 4, 1);
    check("prec.status", status, 0);
    check("prec.result", result, 1);

    // Overflow with 4-bit counter
    cycle(1, 10, 0);
    repeat (15) cycle(0, 10, 1);
    check("ovf.result", result, 15);
    check("ovf.status", status, 2);
    cycle(1, 2, 0);
    cycle(0, 1, 1);
    check("post_ovf.result", result, 1);
    check("post_ovf.status", status, 0);

    // Start mid-measurement is ignored
    cycle(1, 10, 0);
    cycle(0, 9, 1);
    cycle(1, 3, 0);
    cycle(0, 5, 1);
    check("restart.status", status, 0);
    check("restart.result", result, 2);

    // Reset mid-measurement, between edges
    cycle(1, 10, 0);
    cycle(0, 9, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs("midrst");
    @(posedge clk);
    #1;
    check_outs("midrst_hold");
    rst = 1'b0;
    cycle(1, 12, 0);
    foreach (seq[i]) cycle(0, seq[i], 1);
    check("after_rst.result", result, 5);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 5) == 0) ? 1 : 0,
            $urandom_range(0, 15),
            $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/halflife_meter.md
# halflife_meter

Measures the half-life of a decaying 4-bit value stream such as the `out[3:0]` bus of `tt_um_halflife`. On a start strobe it captures the current sample as the reference. It then counts enabled ticks until the sample falls to half the reference (floor) and reports the tick count with a status code. It sits on the observer side of the half-life timer and gives the design a self-check/readback path for the decay period.

## Interface
- `WIDTH`, default 4: sample width in bits.
- `CNT_W`, default 16: width of the tick counter and of `result`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a measurement. Honoured only in IDLE; level-sampled on each edge.
- `sample`  in  WIDTH  monitored value.
- `sample_en`  in  1  tick qualifier; counting and comparison occur only on edges with `sample_en`=1.
- `busy`  out  1  high while in MEAS.
- `done`  out  1  one-cycle pulse when a measurement ends.
- `result`  out  CNT_W  tick count of the last measurement; held until the next `done`.
- `status`  out  2  00 ok, 01 zero reference, 10 overflow, 11 rise abort; held with `result`.

## Operation
- Two states: IDLE and MEAS. Internal registers: `ref` (WIDTH bits) and `count` (CNT_W bits).
- Define `target = ref >> 1` (floor) and `n = count + 1`.

IDLE, on an edge with `start`=1:
- If `sample`=0: `result`<=0, `status`<=01, `done`<=1. Stay in IDLE; `busy` stays 0.
- Otherwise: `ref`<=`sample`, `count`<=0, `busy`<=1, go to MEAS.

MEAS, on an edge with `sample_en`=1, evaluate in this priority order:
1. If `sample` <= `target`: `result`<=n, `status`<=00, finish.
2. Else if `sample` > `ref`: `result`<=n, `status`<=11, finish.
3. Else if n equals 2^CNT_W−1: `result`<=all ones, `status`<=10, finish.
4. Else `count`<=n.

Finishing means `done`<=1, `busy`<=0, go to IDLE.

Other rules:
- MEAS edges with `sample_en`=0 change nothing.
- `start` is ignored in MEAS; no restart or abort.
- All arithmetic is unsigned. `count` never wraps; case 3 fires before wrap.
- `ref`=1 gives `target`=0, so only `sample`=0 completes with status 00.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `status`=00, state IDLE, `ref`=0, `count`=0.
- Reset asserted mid-measurement forces these values immediately, with no `done` pulse.
- Start latency: `busy` is high in the cycle after the `start` edge. The sample present at that same edge becomes `ref`.
- The first comparison happens at the next edge with `sample_en`=1. The tick at that edge counts as 1.
- `done` is registered. It is high for exactly one cycle, starting after the finishing edge. `result`/`status` become valid in that same cycle.
- `busy` falls in the same cycle `done` rises.
- `start` held high in the `done` cycle begins a new measurement at that edge. `done` still pulses only one cycle.
- Back-to-back zero-reference starts give one `done` pulse per start edge.
- Worst-case measurement: 2^CNT_W−1 enabled ticks.

## Test plan
- Decay: `start` with `sample`=12 (target 6), `sample_en`=1 every cycle, `sample` sequence 11,10,9,8,6 → `done` one cycle after the 6, `result`=5, `status`=00, `busy` low in the `done` cycle.
- Gated ticks: same sequence with `sample_en` high every third cycle only (idle cycles hold `sample`) → `result`=5. `done` appears after the fifth enabled edge.
- Zero reference and `ref`=1: `start` with `sample`=0 → `done` next cycle, `result`=0, `status`=01, `busy` never high. `start` with `sample`=1, then 1,1,0 → `result`=3, `status`=00.
- Rise abort and precedence: `ref`=8, then `sample`=9 → `result`=1, `status`=11. Separately, `ref`=8, then `sample`=4 → `status`=00, since halfway takes precedence.
- Overflow: CNT_W=4, `ref`=10, `sample` held at 10 → after 15 ticks `result`=15, `status`=10. A following `start` with `sample`=2 then `sample`=1 → `result`=1, `status`=00.
- Robustness: `start` pulsed mid-MEAS → no effect on `ref`/`count`. Assert `rst` mid-MEAS between edges → outputs zero at once, no `done`. After release, a new measurement works normally.
